// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker: self-seeds, verifies, locks, counts errors and checked bits.
// Optional macro PRBS31_CHK_BITCNT_EN builds the checked-bit counter; otherwise bit_cnt reads 0.
module prbs31_checker #(
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOL_ERRS = 8,
    parameter int ERR_W    = 16,
    parameter int BIT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic             lol,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt
);
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int WI_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WE_W = $clog2(LOL_ERRS + 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(WIN - 1);
    localparam logic [WE_W-1:0] WE_LAST = WE_W'(LOL_ERRS - 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [30:0]     sr;
    logic [30:0]     sr_din;
    logic [4:0]      seed_cnt;
    logic [MC_W-1:0] match_cnt;
    logic [WI_W-1:0] win_idx;
    logic [WE_W-1:0] win_err;
    logic            p, mis, hit, lol_trip;

    assign p      = sr[30] ^ sr[27];
    assign mis    = din ^ p;
    assign sr_din = {sr[29:0], din};
    assign hit    = din_valid && (state == LOCKED) && mis;
    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        lol_trip  = 1'b0;
        if (din_valid) begin
            case (state)
                SEED:
                    if (seed_cnt == 5'd30) state_nxt = (sr_din != '0) ? VERIFY : SEED;
                VERIFY:
                    if (mis || sr_din == '0)     state_nxt = SEED;
                    else if (match_cnt == MC_LAST) state_nxt = LOCKED;
                LOCKED:
                    // win_err holds earlier errors of this window; this one makes LOL_ERRS
                    if (mis && win_err == WE_LAST) begin
                        state_nxt = SEED;
                        lol_trip  = 1'b1;
                    end
                default: state_nxt = SEED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEED;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_idx   <= '0;
            win_err   <= '0;
        end else if (din_valid) begin
            // once locked the local generator free-runs so a flipped bit is a single error
            sr        <= (state == LOCKED) ? {sr[29:0], p} : sr_din;
            seed_cnt  <= (state == SEED && seed_cnt != 5'd30) ? seed_cnt + 5'd1 : '0;
            match_cnt <= (state == VERIFY && state_nxt == VERIFY) ? match_cnt + MC_W'(1) : '0;
            if (state == LOCKED && state_nxt == LOCKED) begin
                win_idx <= (win_idx == WI_LAST) ? '0 : win_idx + WI_W'(1);
                win_err <= (win_idx == WI_LAST) ? '0 : win_err + WE_W'(mis);
            end else begin
                win_idx <= '0;
                win_err <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            lol     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= hit;
            if (clear_cnt) begin
                lol     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (lol_trip) lol <= 1'b1;
                if (hit && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

`ifdef PRBS31_CHK_BITCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                      bit_cnt <= '0;
        else if (clear_cnt)                                           bit_cnt <= '0;
        else if (din_valid && state == LOCKED && bit_cnt != '1)       bit_cnt <= bit_cnt + BIT_W'(1);
    end
`else
    assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: a default instance and an ERR_W=4 instance share one stimulus stream,
// checked against a sequence-level model of the generator and the lock/window rules.
module tb_prbs31_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked_a, err_a, lol_a, locked_b, err_b, lol_b;
    logic [15:0] ec_a;
    logic [3:0]  ec_b;
    logic [31:0] bc_a, bc_b;

    int total = 0;
    int bad   = 0;

    prbs31_checker dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .locked(locked_a), .err(err_a), .lol(lol_a), .err_cnt(ec_a), .bit_cnt(bc_a)
    );

    prbs31_checker #(.ERR_W(4)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
        .locked(locked_b), .err(err_b), .lol(lol_b), .err_cnt(ec_b), .bit_cnt(bc_b)
    );

    always #5 clk = ~clk;

    // generator: stream bit n = bit(n-31) ^ bit(n-28), first 31 bits are the seed
    logic gq[$];
    int   rp;

    // checker model
    int acq, k, cur_win, werr, e_err, e_bits;
    bit mlk, elol;

    task automatic gen_seed(input logic [30:0] s);
        gq.delete();
        rp = 0;
        for (int i = 30; i >= 0; i--) gq.push_back(s[i]);
    endtask

    function automatic logic gnext();
        int n;
        while (gq.size() <= rp) begin
            n = gq.size();
            gq.push_back(gq[n-31] ^ gq[n-28]);
        end
        rp++;
        return gq[rp-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input bit e);
        logic [31:0] exp_bc;
`ifdef PRBS31_CHK_BITCNT_EN
        exp_bc = 32'(e_bits);
`else
        exp_bc = 32'd0;
`endif
        chk("locked",   32'(locked_a), 32'(mlk));
        chk("locked4",  32'(locked_b), 32'(mlk));
        chk("err",      32'(err_a),    32'(e));
        chk("err4",     32'(err_b),    32'(e));
        chk("lol",      32'(lol_a),    32'(elol));
        chk("err_cnt",  32'(ec_a),     32'(e_err));
        chk("err_cnt4", 32'(ec_b),     32'((e_err > 15) ? 15 : e_err));
        chk("bit_cnt",  bc_a,          exp_bc);
    endtask

    task automatic drive(input logic b, input logic v, input logic clr);
        @(negedge clk);
        din       = b;
        din_valid = v;
        clear_cnt = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic model_reset();
        acq = 0; k = 0; cur_win = 0; werr = 0;
        e_err = 0; e_bits = 0; mlk = 0; elol = 0;
    endtask

    // one valid generator bit (optionally flipped), optional clear, optional idle cycle after
    task automatic bit_in(input bit flip, input bit clr, input bit gap);
        bit exp_e;
        exp_e = 0;
        drive(gnext() ^ flip, 1'b1, clr);
        if (!mlk) begin
            acq++;
            if (acq == 31 + 16) begin
                mlk = 1; k = 0; cur_win = 0; werr = 0;
            end
        end else begin
            e_bits++;
            if (k / 64 != cur_win) begin
                cur_win = k / 64;
                werr = 0;
            end
            k++;
            if (flip) begin
                e_err++; werr++; exp_e = 1;
            end
            if (werr == 8) begin
                mlk = 0; elol = 1; acq = 0;
            end
        end
        if (clr) begin
            e_err = 0; e_bits = 0; elol = 0;
        end
        chk_all(exp_e);
        if (gap) begin
            drive(1'($urandom), 1'b0, 1'b0);
            chk_all(0);
        end
    endtask

    initial begin
        bit          pos [64];
        int          cnt, j;
        logic [30:0] s;

        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        chk_all(0);
        @(negedge clk);
        rst = 1'b0;

        // clean stream from all-ones seed
        gen_seed(31'h7FFF_FFFF);
        for (int i = 0; i < 10000; i++) bit_in(0, 0, 0);
        chk("clean_bits_locked", 32'(e_bits), 32'd9953);

        // single isolated error
        repeat ($urandom_range(10, 200)) bit_in(0, 0, 0);
        bit_in(1, 0, 0);
        repeat (5) bit_in(0, 0, 0);

        // eight errors inside one aligned window -> loss of lock, then relock
        while (k % 64 != 0) bit_in(0, 0, 0);
        foreach (pos[i]) pos[i] = 0;
        cnt = 0;
        while (cnt < 8) begin
            j = $urandom_range(0, 63);
            if (!pos[j]) begin
                pos[j] = 1;
                cnt++;
            end
        end
        for (int i = 0; i < 64; i++) bit_in(pos[i] && mlk, 0, 0);
        chk("lol_after_8", 32'(lol_a), 32'd1);
        repeat (100) bit_in(0, 0, 0);

        // clear during idle cycle
        drive(1'b0, 1'b0, 1'b1);
        e_err = 0; e_bits = 0; elol = 0;
        chk_all(0);

        // twenty isolated errors saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(65, 95)) bit_in(0, 0, 0);
            bit_in(1, 0, 0);
        end
        chk("sat4", 32'(ec_b), 32'd15);
        chk("cnt20", 32'(ec_a), 32'd20);

        // clear beats the increment of a simultaneous error
        bit_in(0, 1, 0);
        bit_in(1, 1, 0);
        bit_in(0, 0, 0);

        // asynchronous reset mid-stream while err is high
        bit_in(1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all(0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // random seed, din_valid toggling: lock after 47 valid bits (94 cycles)
        do s = 31'($urandom); while (s == '0);
        gen_seed(s);
        for (int i = 0; i < 70; i++) bit_in(0, 0, 1);
        repeat ($urandom_range(5, 30)) bit_in(0, 0, 0);
        bit_in(1, 0, 1);

        // all-zero input never locks
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 500; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (i % 50 == 49) chk_all(0);
        end
        chk("zero_locked", 32'(locked_a), 32'd0);
        chk("zero_errcnt", 32'(ec_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
